leiwand_rv32_wb_master: RTL and testbench

LEIWAND_RV32_WB_MASTER -- requirements
Module: leiwand_rv32_wb_master

---
 rtl/leiwand_rv32_wb_master_if.sv | 41 ++++
 rtl/leiwand_rv32_wb_master.sv | 154 +++++++++++++++
 tb/tb_leiwand_rv32_wb_master.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/leiwand_rv32_wb_master_if.sv
// Bundle of core request/response and Wishbone B4 pipelined bus signals for the RV32 bus master.
// The master modport is the block's view; the slave modport is the view of whatever surrounds it.
interface leiwand_rv32_wb_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_we;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic [DATA_WIDTH-1:0]   i_req_wdata;
  logic [1:0]              i_req_size;
  logic                    i_req_unsigned;
  logic                    o_rsp_valid;
  logic [DATA_WIDTH-1:0]   o_rsp_rdata;
  logic                    o_rsp_err;
  logic                    o_cyc;
  logic                    o_stb;
  logic                    o_we;
  logic [ADDR_WIDTH-1:0]   o_addr;
  logic [DATA_WIDTH/8-1:0] o_sel;
  logic [DATA_WIDTH-1:0]   o_data;
  logic [DATA_WIDTH-1:0]   i_data;
  logic                    i_ack;
  logic                    i_err;
  logic                    i_stall;

  modport master (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
    input  i_data, i_ack, i_err, i_stall,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_cyc, o_stb, o_we, o_addr, o_sel, o_data
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_size, i_req_unsigned,
    output i_data, i_ack, i_err, i_stall,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_cyc, o_stb, o_we, o_addr, o_sel, o_data
  );
endinterface

// File: rtl/leiwand_rv32_wb_master.sv
// Single-outstanding RV32 load/store to Wishbone B4 pipelined master with lane steering,
// load extension, alignment checking and a bus timeout. Every output is registered.
module leiwand_rv32_wb_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  leiwand_rv32_wb_master_if.master bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int OW = $clog2(SW);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]            state;
  logic [OW-1:0]         off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  we_q;
  logic [CW-1:0]         tmo_cnt;

  logic [OW-1:0]         req_off;
  logic [7:0]            req_lanes;
  logic [SW-1:0]         req_sel;
  logic                  req_illegal;
  logic [DATA_WIDTH-1:0] wmask;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [SW-1:0]         rsp_sel;
  logic [DATA_WIDTH-1:0] rmask;
  logic [DATA_WIDTH-1:0] rshift;
  logic                  sign_bit;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  tmo_hit;

  function automatic logic [7:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      2'd2:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

  // Alignment mask is the access byte count minus one, taken from the lane mask bits.
  always_comb begin
    req_off     = bus.i_req_addr[OW-1:0];
    req_lanes   = lane_mask(bus.i_req_size);
    req_sel     = SW'(req_lanes);
    req_illegal = (|(bus.i_req_addr[2:0] & {req_lanes[4], req_lanes[2], req_lanes[1]})) ||
                  (bus.i_req_size == 2'd3 && DATA_WIDTH == 32);
    wmask = '0;
    for (int i = 0; i < SW; i++) wmask[8*i +: 8] = {8{req_sel[i]}};
    wdata_sh = (bus.i_req_wdata & wmask) << {req_off, 3'b000};

    rsp_sel = SW'(lane_mask(size_q));
    rmask = '0;
    for (int i = 0; i < SW; i++) rmask[8*i +: 8] = {8{rsp_sel[i]}};
    rshift = bus.i_data >> {off_q, 3'b000};
    case (size_q)
      2'd0:    sign_bit = rshift[7];
      2'd1:    sign_bit = rshift[15];
      2'd2:    sign_bit = rshift[31];
      default: sign_bit = rshift[DATA_WIDTH-1];
    endcase
    load_data = (rshift & rmask) | ((sign_bit && !uns_q) ? ~rmask : '0);
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (32'(tmo_cnt) == 32'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= S_IDLE;
      off_q           <= '0;
      size_q          <= '0;
      uns_q           <= 1'b0;
      we_q            <= 1'b0;
      tmo_cnt         <= '0;
      bus.o_req_ready <= 1'b0;
      bus.o_rsp_valid <= 1'b0;
      bus.o_rsp_rdata <= '0;
      bus.o_rsp_err   <= 1'b0;
      bus.o_cyc       <= 1'b0;
      bus.o_stb       <= 1'b0;
      bus.o_we        <= 1'b0;
      bus.o_addr      <= '0;
      bus.o_sel       <= '0;
      bus.o_data      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.o_req_ready <= 1'b1;
          if (bus.i_req_valid && bus.o_req_ready) begin
            bus.o_req_ready <= 1'b0;
            off_q           <= req_off;
            size_q          <= bus.i_req_size;
            uns_q           <= bus.i_req_unsigned;
            we_q            <= bus.i_req_we;
            tmo_cnt         <= '0;
            if (req_illegal) begin
              state           <= S_RESP;
              bus.o_rsp_valid <= 1'b1;
              bus.o_rsp_err   <= 1'b1;
              bus.o_rsp_rdata <= '0;
            end else begin
              state      <= S_REQ;
              bus.o_cyc  <= 1'b1;
              bus.o_stb  <= 1'b1;
              bus.o_we   <= bus.i_req_we;
              bus.o_addr <= bus.i_req_addr & ~(ADDR_WIDTH'(SW - 1));
              bus.o_sel  <= req_sel << req_off;
              bus.o_data <= wdata_sh;
            end
          end
        end
        S_REQ, S_WAIT: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // A slave response wins over a timeout landing on the same cycle.
          if (bus.i_ack || bus.i_err || tmo_hit) begin
            state           <= S_RESP;
            bus.o_cyc       <= 1'b0;
            bus.o_stb       <= 1'b0;
            bus.o_we        <= 1'b0;
            bus.o_addr      <= '0;
            bus.o_sel       <= '0;
            bus.o_data      <= '0;
            bus.o_rsp_valid <= 1'b1;
            if (bus.i_err || !bus.i_ack) begin
              bus.o_rsp_err   <= 1'b1;
              bus.o_rsp_rdata <= '0;
            end else begin
              bus.o_rsp_err   <= 1'b0;
              bus.o_rsp_rdata <= we_q ? '0 : load_data;
            end
          end else if (state == S_REQ && !bus.i_stall) begin
            bus.o_stb <= 1'b0;
            state     <= S_WAIT;
          end
        end
        default: begin
          state           <= S_IDLE;
          bus.o_rsp_valid <= 1'b0;
          bus.o_rsp_err   <= 1'b0;
          bus.o_rsp_rdata <= '0;
          bus.o_req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_leiwand_rv32_wb_master.sv
// Directed bench for leiwand_rv32_wb_master: cycle-exact bus checks in one sequence,
// with responses matched against a queue of expected results.
module tb_leiwand_rv32_wb_master;
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  rsp_t exp_q[$];

  leiwand_rv32_wb_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  leiwand_rv32_wb_master #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Every response pulse must have been announced by the sequence below.
  always @(negedge clk) begin
    if (bus.o_rsp_valid) begin
      checkOutput("rsp_expected", 64'(bus.o_rsp_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        rsp_t e;
        e = exp_q.pop_front();
        checkOutput("rsp_rdata", 64'(bus.o_rsp_rdata), 64'(e.rdata));
        checkOutput("rsp_err", 64'(bus.o_rsp_err), 64'(e.err));
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [1:0] size, input logic uns, input logic want_rsp,
                               input logic [31:0] exp_rdata, input logic exp_err);
    rsp_t e;
    checkOutput("req_ready", 64'(bus.o_req_ready), 64'd1);
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = we;
    bus.i_req_addr     = addr;
    bus.i_req_wdata    = wdata;
    bus.i_req_size     = size;
    bus.i_req_unsigned = uns;
    e.err   = exp_err;
    e.rdata = exp_rdata;
    if (want_rsp) exp_q.push_back(e);
    step();
    bus.i_req_valid = 1'b0;
  endtask

  task automatic runTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns, input logic [31:0] bus_rdata,
                        input logic ack, input logic err, input logic [31:0] exp_addr,
                        input logic [3:0] exp_sel, input logic [31:0] exp_data,
                        input logic [31:0] exp_rdata, input logic exp_err);
    applyStimulus(we, addr, wdata, size, uns, 1'b1, exp_rdata, exp_err);
    checkOutput("c1_cyc", 64'(bus.o_cyc), 64'd1);
    checkOutput("c1_stb", 64'(bus.o_stb), 64'd1);
    checkOutput("c1_we", 64'(bus.o_we), 64'(we));
    checkOutput("c1_addr", 64'(bus.o_addr), 64'(exp_addr));
    checkOutput("c1_sel", 64'(bus.o_sel), 64'(exp_sel));
    checkOutput("c1_data", 64'(bus.o_data), 64'(exp_data));
    step();
    checkOutput("c2_stb", 64'(bus.o_stb), 64'd0);
    checkOutput("c2_cyc", 64'(bus.o_cyc), 64'd1);
    bus.i_ack  = ack;
    bus.i_err  = err;
    bus.i_data = bus_rdata;
    step();
    bus.i_ack = 1'b0;
    bus.i_err = 1'b0;
    checkOutput("c3_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
    checkOutput("c3_cyc", 64'(bus.o_cyc), 64'd0);
    checkOutput("c3_sel", 64'(bus.o_sel), 64'd0);
    step();
    checkOutput("c4_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    checkOutput("c4_ready", 64'(bus.o_req_ready), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.i_req_valid = 1'b0; bus.i_req_we = 1'b0; bus.i_req_addr = '0; bus.i_req_wdata = '0;
    bus.i_req_size = '0; bus.i_req_unsigned = 1'b0; bus.i_data = '0;
    bus.i_ack = 1'b0; bus.i_err = 1'b0; bus.i_stall = 1'b0;

    repeat (3) step();
    checkOutput("rst_ready", 64'(bus.o_req_ready), 64'd0);
    checkOutput("rst_cyc", 64'(bus.o_cyc), 64'd0);
    checkOutput("rst_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
    rst = 1'b0;
    step();
    checkOutput("rel_ready", 64'(bus.o_req_ready), 64'd1);

    $display("[TB] zero-wait loads and stores");
    runTxn(1'b0, 32'h1000_0000, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0,
           32'h1000_0000, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);
    runTxn(1'b1, 32'h1000_0003, 32'h0000_00A5, 2'd0, 1'b0, 32'h1234_5678, 1'b1, 1'b0,
           32'h1000_0000, 4'b1000, 32'hA500_0000, 32'h0, 1'b0);
    runTxn(1'b0, 32'h1000_0002, 32'h0, 2'd0, 1'b0, 32'h0080_0000, 1'b1, 1'b0,
           32'h1000_0000, 4'b0100, 32'h0, 32'hFFFF_FF80, 1'b0);
    runTxn(1'b0, 32'h1000_0002, 32'h0, 2'd0, 1'b1, 32'h0080_0000, 1'b1, 1'b0,
           32'h1000_0000, 4'b0100, 32'h0, 32'h0000_0080, 1'b0);
    runTxn(1'b0, 32'h1000_0006, 32'h0, 2'd1, 1'b0, 32'h8001_0000, 1'b1, 1'b0,
           32'h1000_0004, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0);
    runTxn(1'b1, 32'h1000_0002, 32'hFFFF_BEEF, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0,
           32'h1000_0000, 4'b1100, 32'hBEEF_0000, 32'h0, 1'b0);
    runTxn(1'b0, 32'h2000_0000, 32'h0, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b1,
           32'h2000_0000, 4'hF, 32'h0, 32'h0, 1'b1);

    $display("[TB] misaligned and oversized accesses");
    applyStimulus(1'b0, 32'h1000_0001, 32'h0, 2'd1, 1'b0, 1'b1, 32'h0, 1'b1);
    checkOutput("mis_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
    checkOutput("mis_cyc1", 64'(bus.o_cyc), 64'd0);
    step();
    checkOutput("mis_cyc2", 64'(bus.o_cyc), 64'd0);
    applyStimulus(1'b0, 32'h1000_0000, 32'h0, 2'd3, 1'b0, 1'b1, 32'h0, 1'b1);
    checkOutput("dw_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
    checkOutput("dw_cyc", 64'(bus.o_cyc), 64'd0);
    step();

    $display("[TB] stalled strobe");
    applyStimulus(1'b0, 32'h1000_0008, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0BAD_CAFE, 1'b0);
    bus.i_stall = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) bus.i_stall = 1'b0;
      checkOutput($sformatf("stall_stb_c%0d", c), 64'(bus.o_stb), 64'd1);
      step();
    end
    checkOutput("stall_stb_c5", 64'(bus.o_stb), 64'd0);
    checkOutput("stall_cyc_c5", 64'(bus.o_cyc), 64'd1);
    step();
    bus.i_ack  = 1'b1;
    bus.i_data = 32'h0BAD_CAFE;
    step();
    bus.i_ack = 1'b0;
    checkOutput("stall_rsp_c7", 64'(bus.o_rsp_valid), 64'd1);
    step();

    $display("[TB] bus timeout");
    applyStimulus(1'b0, 32'h3000_0000, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      checkOutput($sformatf("tmo_cyc_c%0d", c), 64'(bus.o_cyc), 64'd1);
      checkOutput($sformatf("tmo_rsp_c%0d", c), 64'(bus.o_rsp_valid), 64'd0);
      step();
    end
    checkOutput("tmo_cyc_c9", 64'(bus.o_cyc), 64'd0);
    checkOutput("tmo_rsp_c9", 64'(bus.o_rsp_valid), 64'd1);
    step();

    $display("[TB] reset during a transaction");
    applyStimulus(1'b0, 32'h4000_0000, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rstmid_cyc", 64'(bus.o_cyc), 64'd0);
    checkOutput("rstmid_stb", 64'(bus.o_stb), 64'd0);
    step();
    checkOutput("rstmid_ready", 64'(bus.o_req_ready), 64'd1);
    checkOutput("rstmid_rsp", 64'(bus.o_rsp_valid), 64'd0);
    bus.i_ack = 1'b1;
    step();
    bus.i_ack = 1'b0;
    checkOutput("idle_ack_rsp", 64'(bus.o_rsp_valid), 64'd0);
    checkOutput("idle_ack_cyc", 64'(bus.o_cyc), 64'd0);
    repeat (2) step();
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
